// File: rtl/mem_stage.sv
// Memory-access stage with the MEM/WB pipeline register. It issues loads and stores
// over a single-outstanding req/ack bus and retires ALU results, load data and faults.

package mem_stage_pkg;

    typedef enum logic [3:0] {
        MEM_OP_NONE = 4'd0,
        MEM_OP_LB   = 4'd1,
        MEM_OP_LBU  = 4'd2,
        MEM_OP_LH   = 4'd3,
        MEM_OP_LHU  = 4'd4,
        MEM_OP_LW   = 4'd5,
        MEM_OP_SB   = 4'd6,
        MEM_OP_SH   = 4'd7,
        MEM_OP_SW   = 4'd8
    } mem_op_t;

    typedef struct packed {
        logic [4:0]  rd_addr;
        logic [31:0] rd_data;
        mem_op_t     mem_op;
        logic [31:0] mem_data;
    } mem_params_t;

    typedef enum logic [1:0] {
        FAULT_NONE       = 2'b00,
        FAULT_MISALIGNED = 2'b01,
        FAULT_TIMEOUT    = 2'b10
    } fault_cause_t;

endpackage

module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int REG_ADDR_W     = 5,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_valid,
    input  mem_params_t           mem_params,
    output logic                  stall,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [31:0]           bus_addr,
    output logic [31:0]           bus_wdata,
    output logic [3:0]            bus_be,
    input  logic [31:0]           bus_rdata,
    input  logic                  bus_ack,
    output logic                  wb_valid,
    output logic                  wb_rd_we,
    output logic [REG_ADDR_W-1:0] wb_rd_addr,
    output logic [31:0]           wb_rd_data,
    output logic                  fault,
    output logic [1:0]            fault_cause,
    output logic [31:0]           fault_addr
);

    typedef enum logic {IDLE, BUS} state_t;

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t            state;
    logic [CNT_W-1:0]  cnt;

    mem_op_t     op;
    logic [31:0] ea;
    logic        is_load;
    logic        is_store;
    logic        is_half;
    logic        is_word;
    logic        misaligned;
    logic        needs_bus;
    logic        timeout_hit;
    logic        rd_nonzero;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [31:0] lane;
    logic [31:0] load_data;

    assign op         = mem_params.mem_op;
    assign ea         = mem_params.rd_data;
    assign is_load    = op inside {MEM_OP_LB, MEM_OP_LBU, MEM_OP_LH, MEM_OP_LHU, MEM_OP_LW};
    assign is_store   = op inside {MEM_OP_SB, MEM_OP_SH, MEM_OP_SW};
    assign is_half    = op inside {MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH};
    assign is_word    = op inside {MEM_OP_LW, MEM_OP_SW};
    assign misaligned = (is_half && ea[0]) || (is_word && (ea[1:0] != 2'b00));
    assign needs_bus  = mem_valid && (is_load || is_store) && !misaligned;
    assign rd_nonzero = (mem_params.rd_addr != 5'd0);
    assign lane       = bus_rdata >> {ea[1:0], 3'b000};

    assign timeout_hit = (TIMEOUT_CYCLES > 0) && (state == BUS) && !bus_ack && (cnt == CNT_LAST);

    // Upstream only sees a stall while a bus op is being launched or is still awaiting ack;
    // the ack or timeout cycle releases it so the next op can be presented right away.
    assign stall = (state == IDLE) ? needs_bus : (!bus_ack && !timeout_hit);

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        be_next    = 4'b1111;
        wdata_next = mem_params.mem_data;
        load_data  = bus_rdata;
        if (is_half) begin
            be_next    = 4'b0011 << ea[1:0];
            wdata_next = {2{mem_params.mem_data[15:0]}};
        end else if (!is_word) begin
            be_next    = 4'b0001 << ea[1:0];
            wdata_next = {4{mem_params.mem_data[7:0]}};
        end
        case (op)
            MEM_OP_LB:  load_data = {{24{lane[7]}}, lane[7:0]};
            MEM_OP_LBU: load_data = {24'd0, lane[7:0]};
            MEM_OP_LH:  load_data = {{16{lane[15]}}, lane[15:0]};
            MEM_OP_LHU: load_data = {16'd0, lane[15:0]};
            default:    load_data = bus_rdata;
        endcase
    end

    // NOTE: state and registered outputs use non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
            bus_be      <= '0;
            wb_valid    <= 1'b0;
            wb_rd_we    <= 1'b0;
            wb_rd_addr  <= '0;
            wb_rd_data  <= '0;
            fault       <= 1'b0;
            fault_cause <= FAULT_NONE;
            fault_addr  <= '0;
        end else begin
            fault       <= 1'b0;
            fault_cause <= FAULT_NONE;
            case (state)
                IDLE: begin
                    wb_rd_addr <= REG_ADDR_W'(mem_params.rd_addr);
                    if (!mem_valid) begin
                        wb_valid <= 1'b0;
                        wb_rd_we <= 1'b0;
                    end else if (op == MEM_OP_NONE) begin
                        wb_valid   <= 1'b1;
                        wb_rd_we   <= rd_nonzero;
                        wb_rd_data <= ea;
                    end else if (misaligned) begin
                        wb_valid    <= 1'b1;
                        wb_rd_we    <= 1'b0;
                        fault       <= 1'b1;
                        fault_cause <= FAULT_MISALIGNED;
                        fault_addr  <= ea;
                    end else begin
                        wb_valid  <= 1'b0;
                        wb_rd_we  <= 1'b0;
                        bus_req   <= 1'b1;
                        bus_we    <= is_store;
                        bus_addr  <= {ea[31:2], 2'b00};
                        bus_be    <= be_next;
                        bus_wdata <= wdata_next;
                        cnt       <= '0;
                        state     <= BUS;
                    end
                end
                BUS: begin
                    // mem_params is held by upstream, so the ack cycle re-reads it directly.
                    wb_rd_addr <= REG_ADDR_W'(mem_params.rd_addr);
                    if (bus_ack) begin
                        bus_req    <= 1'b0;
                        state      <= IDLE;
                        wb_valid   <= 1'b1;
                        wb_rd_we   <= is_load && rd_nonzero;
                        wb_rd_data <= is_load ? load_data : ea;
                    end else if (timeout_hit) begin
                        bus_req     <= 1'b0;
                        state       <= IDLE;
                        wb_valid    <= 1'b1;
                        wb_rd_we    <= 1'b0;
                        fault       <= 1'b1;
                        fault_cause <= FAULT_TIMEOUT;
                        fault_addr  <= ea;
                    end else begin
                        wb_valid <= 1'b0;
                        cnt      <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a driver issues ops and pushes expected writebacks,
// a monitor pops and compares them whenever wb_valid is seen, a responder plays the bus.

module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    mem_params_t mem_params;
    logic        stall;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        wb_valid;
    logic        wb_rd_we;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_rd_data;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [31:0] fault_addr;

    mem_stage #(.REG_ADDR_W(5), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_params(mem_params),
        .stall(stall), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .wb_valid(wb_valid), .wb_rd_we(wb_rd_we), .wb_rd_addr(wb_rd_addr),
        .wb_rd_data(wb_rd_data), .fault(fault), .fault_cause(fault_cause),
        .fault_addr(fault_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd_we;
        logic [4:0]  rd_addr;
        logic [31:0] rd_data;
        logic        fault;
        logic [1:0]  cause;
        logic [31:0] fault_addr;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    int          ack_delay = -1;
    logic [31:0] rdata_val = '0;
    int          req_cycles = 0;
    int          last_req_len = 0;
    int          total_req = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic rd_we, input logic [4:0] rd_addr,
                                input logic [31:0] rd_data, input logic flt,
                                input logic [1:0] cause, input logic [31:0] faddr);
        exp_t e;
        e.rd_we      = rd_we;
        e.rd_addr    = rd_addr;
        e.rd_data    = rd_data;
        e.fault      = flt;
        e.cause      = cause;
        e.fault_addr = faddr;
        return e;
    endfunction

    // Bus responder: acks after ack_delay BUS cycles (negative = never), tracks request lengths.
    initial begin
        bus_ack   = 1'b0;
        bus_rdata = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            bus_ack   = 1'b0;
            bus_rdata = 32'hDEAD_BEEF;
            if (bus_req) begin
                total_req++;
                if (ack_delay >= 0 && req_cycles == ack_delay) begin
                    bus_ack   = 1'b1;
                    bus_rdata = rdata_val;
                end
                req_cycles++;
            end else begin
                if (req_cycles > 0) last_req_len = req_cycles;
                req_cycles = 0;
            end
        end
    end

    // Monitor: compares each retired instruction against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && wb_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wb_unexpected: got wb_valid=1 rd=%0d data=0x%08h, expected none",
                             wb_rd_addr, wb_rd_data);
                end else begin
                    e = exp_q.pop_front();
                    check("wb_rd_we", {31'd0, wb_rd_we}, {31'd0, e.rd_we});
                    if (e.rd_we) begin
                        check("wb_rd_addr", {27'd0, wb_rd_addr}, {27'd0, e.rd_addr});
                        check("wb_rd_data", wb_rd_data, e.rd_data);
                    end
                    check("wb_fault", {31'd0, fault}, {31'd0, e.fault});
                    if (e.fault) begin
                        check("fault_cause", {30'd0, fault_cause}, {30'd0, e.cause});
                        check("fault_addr", fault_addr, e.fault_addr);
                    end
                end
            end else if (!rst && fault) begin
                checks++;
                errors++;
                $display("FAIL fault_without_wb: got fault=1 wb_valid=0, expected fault=0");
            end
        end
    end

    int          sc;
    logic [3:0]  cbe;
    logic [31:0] caddr;
    logic [31:0] cwdata;
    logic        cwe;
    logic        cstable;

    // Presents one op starting just after a rising edge, waits until it is consumed
    // (stall low), and returns how many stall cycles it saw plus the first bus snapshot.
    task automatic do_op(input mem_op_t op, input logic [4:0] rd, input logic [31:0] ea,
                         input logic [31:0] md, input int delay, input logic [31:0] rdata,
                         output int stall_cycles, output logic [3:0] be, output logic [31:0] addr,
                         output logic [31:0] wdata, output logic we, output logic stable);
        bit seen;
        seen         = 1'b0;
        stall_cycles = 0;
        stable       = 1'b1;
        be           = '0;
        addr         = '0;
        wdata        = '0;
        we           = 1'b0;
        ack_delay    = delay;
        rdata_val    = rdata;
        mem_params   = '{rd_addr: rd, rd_data: ea, mem_op: op, mem_data: md};
        mem_valid    = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            #1;
            if (bus_req) begin
                if (!seen) begin
                    be    = bus_be;
                    addr  = bus_addr;
                    wdata = bus_wdata;
                    we    = bus_we;
                    seen  = 1'b1;
                end else if (bus_be !== be || bus_addr !== addr || bus_wdata !== wdata || bus_we !== we) begin
                    stable = 1'b0;
                end
            end
            if (!stall) break;
            stall_cycles++;
            if (i == 63) begin
                checks++;
                errors++;
                $display("FAIL stall_bound: got stall still high after 64 cycles, expected release");
            end
        end
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        check("wb_latency", {31'd0, wb_valid}, 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int t0;

    initial begin
        rst        = 1'b1;
        mem_valid  = 1'b0;
        mem_params = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_bus_req", {31'd0, bus_req}, 32'd0);
        check("rst_bus_be", {28'd0, bus_be}, 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_wb_rd_data", wb_rd_data, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_fault_addr", fault_addr, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(1);

        // ALU passthrough
        exp_q.push_back(mk(1'b1, 5'd3, 32'h1234_5678, 1'b0, 2'b00, 32'd0));
        do_op(MEM_OP_NONE, 5'd3, 32'h1234_5678, 32'd0, -1, 32'd0, sc, cbe, caddr, cwdata, cwe, cstable);
        check("alu_stall", sc, 32'd0);

        // LB / LBU from byte lane 3
        exp_q.push_back(mk(1'b1, 5'd5, 32'hFFFF_FF80, 1'b0, 2'b00, 32'd0));
        do_op(MEM_OP_LB, 5'd5, 32'h0000_0103, 32'd0, 0, 32'h80FF_FFFF, sc, cbe, caddr, cwdata, cwe, cstable);
        check("lb_be", {28'd0, cbe}, 32'b1000);
        check("lb_addr", caddr, 32'h0000_0100);
        check("lb_we", {31'd0, cwe}, 32'd0);
        check("lb_stall", sc, 32'd1);
        exp_q.push_back(mk(1'b1, 5'd6, 32'h0000_0080, 1'b0, 2'b00, 32'd0));
        do_op(MEM_OP_LBU, 5'd6, 32'h0000_0103, 32'd0, 0, 32'h80FF_FFFF, sc, cbe, caddr, cwdata, cwe, cstable);
        check("lbu_stall", sc, 32'd1);

        // SH with ack three cycles late
        exp_q.push_back(mk(1'b0, 5'd4, 32'd0, 1'b0, 2'b00, 32'd0));
        do_op(MEM_OP_SH, 5'd4, 32'h0000_0202, 32'hAAAA_BEEF, 3, 32'd0, sc, cbe, caddr, cwdata, cwe, cstable);
        check("sh_we", {31'd0, cwe}, 32'd1);
        check("sh_be", {28'd0, cbe}, 32'b1100);
        check("sh_wdata", cwdata, 32'hBEEF_BEEF);
        check("sh_stable", {31'd0, cstable}, 32'd1);
        check("sh_stall", sc, 32'd4);
        idle(1);
        check("sh_req_len", last_req_len, 32'd4);

        // Misaligned LW: no bus activity, fault cause 01
        t0 = total_req;
        exp_q.push_back(mk(1'b0, 5'd7, 32'd0, 1'b1, 2'b01, 32'h0000_0301));
        do_op(MEM_OP_LW, 5'd7, 32'h0000_0301, 32'd0, 0, 32'd0, sc, cbe, caddr, cwdata, cwe, cstable);
        check("mis_stall", sc, 32'd0);
        idle(1);
        check("mis_no_req", total_req - t0, 32'd0);

        // Timeout: no ack at all
        exp_q.push_back(mk(1'b0, 5'd8, 32'd0, 1'b1, 2'b10, 32'h0000_0400));
        do_op(MEM_OP_LW, 5'd8, 32'h0000_0400, 32'd0, -1, 32'd0, sc, cbe, caddr, cwdata, cwe, cstable);
        check("to_stall", sc, 32'd4);
        idle(1);
        check("to_req_len", last_req_len, 32'd4);

        // Ack on the final allowed cycle wins over the timeout
        exp_q.push_back(mk(1'b1, 5'd9, 32'hCAFE_F00D, 1'b0, 2'b00, 32'd0));
        do_op(MEM_OP_LW, 5'd9, 32'h0000_0404, 32'd0, 3, 32'hCAFE_F00D, sc, cbe, caddr, cwdata, cwe, cstable);
        check("ack4_stall", sc, 32'd4);
        idle(1);
        check("ack4_req_len", last_req_len, 32'd4);

        // Back-to-back SW then LH then LHU to x0; the store must not be re-issued
        t0 = total_req;
        exp_q.push_back(mk(1'b0, 5'd2, 32'd0, 1'b0, 2'b00, 32'd0));
        do_op(MEM_OP_SW, 5'd2, 32'h0000_0500, 32'h1122_3344, 0, 32'd0, sc, cbe, caddr, cwdata, cwe, cstable);
        check("sw_wdata", cwdata, 32'h1122_3344);
        check("sw_be", {28'd0, cbe}, 32'b1111);
        exp_q.push_back(mk(1'b1, 5'd10, 32'hFFFF_8001, 1'b0, 2'b00, 32'd0));
        do_op(MEM_OP_LH, 5'd10, 32'h0000_0502, 32'd0, 0, 32'h8001_0000, sc, cbe, caddr, cwdata, cwe, cstable);
        check("lh_we", {31'd0, cwe}, 32'd0);
        check("lh_be", {28'd0, cbe}, 32'b1100);
        exp_q.push_back(mk(1'b0, 5'd0, 32'd0, 1'b0, 2'b00, 32'd0));
        do_op(MEM_OP_LHU, 5'd0, 32'h0000_0500, 32'd0, 0, 32'h1234_FFFF, sc, cbe, caddr, cwdata, cwe, cstable);
        idle(1);
        check("b2b_req_count", total_req - t0, 32'd3);

        // SB to lane 1
        exp_q.push_back(mk(1'b0, 5'd1, 32'd0, 1'b0, 2'b00, 32'd0));
        do_op(MEM_OP_SB, 5'd1, 32'h0000_0601, 32'hABCD_EF5A, 1, 32'd0, sc, cbe, caddr, cwdata, cwe, cstable);
        check("sb_be", {28'd0, cbe}, 32'b0010);
        check("sb_wdata", cwdata, 32'h5A5A_5A5A);
        check("sb_addr", caddr, 32'h0000_0600);

        // Reset asserted while a request is outstanding
        ack_delay  = -1;
        mem_params = '{rd_addr: 5'd11, rd_data: 32'h0000_0700, mem_op: MEM_OP_LW, mem_data: 32'd0};
        mem_valid  = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("mid_bus_req", {31'd0, bus_req}, 32'd1);
        rst       = 1'b1;
        mem_valid = 1'b0;
        #1;
        check("mid_rst_bus_req", {31'd0, bus_req}, 32'd0);
        check("mid_rst_stall", {31'd0, stall}, 32'd0);
        check("mid_rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(1);
        exp_q.push_back(mk(1'b1, 5'd12, 32'h0BAD_F00D, 1'b0, 2'b00, 32'd0));
        do_op(MEM_OP_LW, 5'd12, 32'h0000_0704, 32'd0, 1, 32'h0BAD_F00D, sc, cbe, caddr, cwdata, cwe, cstable);
        check("post_rst_addr", caddr, 32'h0000_0704);
        check("post_rst_stall", sc, 32'd2);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
        idle(2);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
